// File: rtl/hack_boot_loader.sv
// Streams a program image into the Hack instruction ROM and holds the CPU in reset until the image is in.
// Optional macro HACK_BOOT_CHECKSUM_EN: the s_last word is a checksum over the written words, not program data.
module hack_boot_loader #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WIDTH-1:0]  s_data,
  input  logic              s_last,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [WIDTH-1:0]  rom_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              xfer, wr, at_top, sum_ok;

  // s_ready is a registered copy of (state == LOAD), so no transfer can happen elsewhere
  assign xfer   = s_valid & s_ready;
  assign at_top = &addr;

`ifdef HACK_BOOT_CHECKSUM_EN
  logic [WIDTH-1:0] sum;
  assign wr     = xfer & ~s_last;
  assign sum_ok = (sum == s_data);
`else
  assign wr     = xfer;
  assign sum_ok = 1'b1;
`endif

  assign rom_we   = wr;
  assign rom_addr = wr ? addr : '0;
  assign rom_data = wr ? s_data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      word_count <= '0;
      s_ready    <= 1'b0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef HACK_BOOT_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      case (state)
        IDLE, RUN, ERR: begin
          if (start) begin
            state      <= LOAD;
            addr       <= '0;
            word_count <= '0;
            s_ready    <= 1'b1;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef HACK_BOOT_CHECKSUM_EN
            sum        <= '0;
`endif
          end
        end
        LOAD: begin
          if (wr) begin
            addr       <= addr + 1'b1;
            word_count <= word_count + 1'b1;
`ifdef HACK_BOOT_CHECKSUM_EN
            sum        <= sum + s_data;
`endif
          end
          // start is deliberately ignored here; only the stream can end a load
          if (xfer && s_last && sum_ok) begin
            state     <= RUN;
            s_ready   <= 1'b0;
            cpu_reset <= 1'b0;
            done      <= 1'b1;
          end else if (xfer && (s_last || at_top)) begin
            state     <= ERR;
            s_ready   <= 1'b0;
            error     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_boot_loader.sv
// Directed vector table plus hand-written corner sequences for hack_boot_loader.
module tb_hack_boot_loader;
  localparam int W = 16, AW = 15, AW2 = 2;

  logic clk = 1'b0;
  logic reset;
  logic start, s_valid, s_last, s_ready, rom_we, cpu_reset, done, error;
  logic [W-1:0] s_data, rom_data;
  logic [AW-1:0] rom_addr;
  logic [AW:0] word_count;

  logic start2, s_valid2, s_last2, s_ready2, rom_we2, cpu_reset2, done2, error2;
  logic [W-1:0] s_data2, rom_data2;
  logic [AW2-1:0] rom_addr2;
  logic [AW2:0] word_count2;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  hack_boot_loader #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_data(rom_data), .cpu_reset(cpu_reset), .done(done), .error(error),
    .word_count(word_count));

  hack_boot_loader #(.WIDTH(W), .ADDR_W(AW2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .s_valid(s_valid2), .s_ready(s_ready2),
    .s_data(s_data2), .s_last(s_last2), .rom_we(rom_we2), .rom_addr(rom_addr2),
    .rom_data(rom_data2), .cpu_reset(cpu_reset2), .done(done2), .error(error2),
    .word_count(word_count2));

  typedef struct {
    logic st, v, l;
    logic [15:0] d;
    logic we;
    logic [14:0] a;
    logic rdy, cr, dn, er;
    logic [15:0] wc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic v, logic [15:0] d, logic l, logic we,
                              logic [14:0] a, logic rdy, logic cr, logic dn, logic er,
                              logic [15:0] wc);
    vec_t x;
    x.st = st; x.v = v; x.d = d; x.l = l; x.we = we; x.a = a;
    x.rdy = rdy; x.cr = cr; x.dn = dn; x.er = er; x.wc = wc;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 0; s_valid = 0; s_last = 0; s_data = '0;
    start2 = 0; s_valid2 = 0; s_last2 = 0; s_data2 = '0;

    // fields: start valid data last | we addr ready cpu_reset done error word_count
`ifdef HACK_BOOT_CHECKSUM_EN
    tbl.push_back(mk(0,0,16'h0000,0, 0,0, 0,1,0,0, 0));
    tbl.push_back(mk(1,0,16'h0000,0, 0,0, 0,1,0,0, 0));
    tbl.push_back(mk(0,1,16'h0005,0, 1,0, 1,1,0,0, 0));
    tbl.push_back(mk(0,1,16'h0007,0, 1,1, 1,1,0,0, 1));
    tbl.push_back(mk(0,1,16'h000C,1, 0,0, 1,1,0,0, 2));
    tbl.push_back(mk(0,0,16'h0000,0, 0,0, 0,0,1,0, 2));
    tbl.push_back(mk(1,0,16'h0000,0, 0,0, 0,0,1,0, 2));
    tbl.push_back(mk(0,0,16'h0000,0, 0,0, 1,1,0,0, 0));
    tbl.push_back(mk(0,1,16'h0005,0, 1,0, 1,1,0,0, 0));
    tbl.push_back(mk(0,1,16'h0007,0, 1,1, 1,1,0,0, 1));
    tbl.push_back(mk(0,1,16'h000D,1, 0,0, 1,1,0,0, 2));
    tbl.push_back(mk(0,0,16'h0000,0, 0,0, 0,1,0,1, 2));
    tbl.push_back(mk(1,0,16'h0000,0, 0,0, 0,1,0,1, 2));
    tbl.push_back(mk(0,0,16'h0000,0, 0,0, 1,1,0,0, 0));
    tbl.push_back(mk(0,1,16'h0000,1, 0,0, 1,1,0,0, 0));
    tbl.push_back(mk(0,0,16'h0000,0, 0,0, 0,0,1,0, 0));
`else
    tbl.push_back(mk(0,0,16'h0000,0, 0,0, 0,1,0,0, 0));
    tbl.push_back(mk(1,0,16'h0000,0, 0,0, 0,1,0,0, 0));
    tbl.push_back(mk(0,1,16'h0002,0, 1,0, 1,1,0,0, 0));
    tbl.push_back(mk(0,0,16'h1234,0, 0,0, 1,1,0,0, 1));
    tbl.push_back(mk(0,1,16'hEC10,0, 1,1, 1,1,0,0, 1));
    tbl.push_back(mk(1,1,16'h0003,1, 1,2, 1,1,0,0, 2));
    tbl.push_back(mk(0,0,16'h0000,0, 0,0, 0,0,1,0, 3));
    tbl.push_back(mk(0,1,16'h5555,0, 0,0, 0,0,1,0, 3));
    tbl.push_back(mk(1,0,16'h0000,0, 0,0, 0,0,1,0, 3));
    tbl.push_back(mk(0,0,16'h0000,0, 0,0, 1,1,0,0, 0));
    tbl.push_back(mk(0,1,16'h0101,0, 1,0, 1,1,0,0, 0));
    tbl.push_back(mk(0,0,16'hFFFF,0, 0,0, 1,1,0,0, 1));
    tbl.push_back(mk(0,1,16'h0102,0, 1,1, 1,1,0,0, 1));
    tbl.push_back(mk(0,1,16'h0103,0, 1,2, 1,1,0,0, 2));
    tbl.push_back(mk(0,0,16'hAAAA,1, 0,0, 1,1,0,0, 3));
    tbl.push_back(mk(0,0,16'h0000,0, 0,0, 1,1,0,0, 3));
    tbl.push_back(mk(0,1,16'h0104,0, 1,3, 1,1,0,0, 3));
    tbl.push_back(mk(0,0,16'h0000,0, 0,0, 1,1,0,0, 4));
    tbl.push_back(mk(0,1,16'h0105,1, 1,4, 1,1,0,0, 4));
    tbl.push_back(mk(0,0,16'h0000,0, 0,0, 0,0,1,0, 5));
`endif

    // reset state, with s_valid asserted to show it is ignored
    @(negedge clk); s_valid = 1; s_data = 16'hBEEF;
    #1;
    chk("rst s_ready", s_ready, 0);
    chk("rst rom_we", rom_we, 0);
    chk("rst rom_addr", rom_addr, 0);
    chk("rst rom_data", rom_data, 0);
    chk("rst cpu_reset", cpu_reset, 1);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    chk("rst word_count", word_count, 0);
    @(negedge clk); reset = 1'b0; s_valid = 0; s_data = '0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      start = tbl[i].st; s_valid = tbl[i].v; s_data = tbl[i].d; s_last = tbl[i].l;
      #1;
      chk($sformatf("v%0d rom_we", i), rom_we, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("v%0d rom_addr", i), rom_addr, tbl[i].a);
        chk($sformatf("v%0d rom_data", i), rom_data, tbl[i].d);
      end
      chk($sformatf("v%0d s_ready", i), s_ready, tbl[i].rdy);
      chk($sformatf("v%0d cpu_reset", i), cpu_reset, tbl[i].cr);
      chk($sformatf("v%0d done", i), done, tbl[i].dn);
      chk($sformatf("v%0d error", i), error, tbl[i].er);
      chk($sformatf("v%0d word_count", i), word_count, tbl[i].wc);
    end
    @(negedge clk); start = 0; s_valid = 0; s_last = 0; s_data = '0;

    // reset in the middle of a load
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; s_valid = 1; s_data = 16'hAAAA;
    @(negedge clk); s_data = 16'hBBBB;
    @(negedge clk); s_data = 16'hCCCC;
    #1;
    chk("mid we before reset", rom_we, 1);
    chk("mid addr before reset", rom_addr, 2);
    #1 reset = 1'b1;
    #1;
    chk("mid s_ready", s_ready, 0);
    chk("mid cpu_reset", cpu_reset, 1);
    chk("mid rom_we", rom_we, 0);
    chk("mid word_count", word_count, 0);
    chk("mid done", done, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) reset = 1'b0;
      #1;
      chk($sformatf("post rst %0d rom_we", k), rom_we, 0);
      chk($sformatf("post rst %0d s_ready", k), s_ready, 0);
    end
    s_valid = 0;

    // overflow on the 4-entry instance
    @(negedge clk); start2 = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); start2 = 0; s_valid2 = 1; s_data2 = 16'h0010 + 16'(k); s_last2 = 0;
      #1;
      chk($sformatf("ovf %0d rom_we", k), rom_we2, 1);
      chk($sformatf("ovf %0d rom_addr", k), rom_addr2, k);
      chk($sformatf("ovf %0d rom_data", k), rom_data2, 16'h0010 + 16'(k));
    end
    @(negedge clk); s_valid2 = 0;
    #1;
    chk("ovf error", error2, 1);
    chk("ovf cpu_reset", cpu_reset2, 1);
    chk("ovf s_ready", s_ready2, 0);
    chk("ovf word_count", word_count2, 4);
    chk("ovf done", done2, 0);
    @(negedge clk); start2 = 1;
    @(negedge clk); start2 = 0;
    #1;
    chk("retry s_ready", s_ready2, 1);
    chk("retry word_count", word_count2, 0);
    chk("retry error", error2, 0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
